// File: rtl/reflex_game_ctrl.sv
// Round controller for the reflex trainer: runs a fixed-length round,
// lights pseudo-random one-hot targets, judges button presses and keeps
// a saturating score. All outputs come straight from registers.
module reflex_game_ctrl #(
  parameter int TICK_DIV       = 100000000,
  parameter int GAME_SECONDS   = 30,
  parameter int TARGET_TIMEOUT = 150000000,
  parameter int SCORE_MAX      = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] target_led,
  output logic [4:0] elapsed_time,
  output logic [6:0] score,
  output logic       busy,
  output logic       game_over
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int TO_W   = $clog2(TARGET_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [7:0]        r_lfsr;
  logic [1:0]        r_prev;
  logic [TICK_W-1:0] r_tick;
  logic [TO_W-1:0]   r_to;
  logic [3:0]        r_target;
  logic [4:0]        r_elapsed;
  logic [6:0]        r_score;
  logic              r_busy;
  logic              r_game_over;

  logic       w_lfsr_fb;
  logic [1:0] w_cand;
  logic       w_running;
  logic       w_tick_wrap;
  logic       w_final_tick;
  logic       w_hit;
  logic       w_miss;
  logic       w_timeout;

  function automatic logic [6:0] f_sat_inc(input logic [6:0] v);
    return (v >= 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : v + 7'd1;
  endfunction

  function automatic logic [6:0] f_sat_dec(input logic [6:0] v);
    return (v == 7'd0) ? 7'd0 : v - 7'd1;
  endfunction

  // Taps x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // Never light the same LED twice in a row: bump a repeat to the next one.
  assign w_cand    = (r_lfsr[1:0] == r_prev) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];

  assign w_running    = (r_state == S_ARM) || (r_state == S_WAIT);
  assign w_tick_wrap  = w_running && (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_final_tick = w_tick_wrap && (r_elapsed == 5'(GAME_SECONDS - 1));
  // A hit is exactly the lit bit; any extra or different bit is a miss.
  assign w_hit        = (btn == r_target) && (r_target != 4'd0);
  assign w_miss       = (btn != 4'd0) && ((btn & ~r_target) != 4'd0);
  assign w_timeout    = (r_to == TO_W'(TARGET_TIMEOUT - 1));

  assign target_led   = r_target;
  assign elapsed_time = r_elapsed;
  assign score        = r_score;
  assign busy         = r_busy;
  assign game_over    = r_game_over;

  // Free-running target generator, reseeded only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  // Round FSM with second timer, target selection and scoring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prev      <= 2'd0;
      r_tick      <= '0;
      r_to        <= '0;
      r_target    <= 4'd0;
      r_elapsed   <= 5'd0;
      r_score     <= 7'd0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      if (w_running) begin
        if (w_tick_wrap) begin
          r_tick    <= '0;
          r_elapsed <= r_elapsed + 5'd1;
        end else begin
          r_tick <= r_tick + TICK_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ARM;
            r_busy    <= 1'b1;
            r_elapsed <= 5'd0;
            r_score   <= 7'd0;
            r_tick    <= '0;
          end
        end
        S_ARM: begin
          r_target <= 4'b0001 << w_cand;
          r_prev   <= w_cand;
          r_to     <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_hit) begin
            r_score  <= f_sat_inc(r_score);
            r_target <= 4'd0;
            r_state  <= S_ARM;
          end else if (w_miss) begin
            r_score  <= f_sat_dec(r_score);
            r_target <= 4'd0;
            r_state  <= S_ARM;
          end else if (w_timeout) begin
            r_target <= 4'd0;
            r_state  <= S_ARM;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            r_state     <= S_ARM;
            r_busy      <= 1'b1;
            r_game_over <= 1'b0;
            r_elapsed   <= 5'd0;
            r_score     <= 7'd0;
            r_tick      <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Restart beats end-of-round; end-of-round beats the WAIT/ARM outcome
      // but keeps any score change made above.
      if (w_running) begin
        if (start) begin
          r_state   <= S_ARM;
          r_target  <= 4'd0;
          r_elapsed <= 5'd0;
          r_score   <= 7'd0;
          r_tick    <= '0;
        end else if (w_final_tick) begin
          r_state     <= S_DONE;
          r_target    <= 4'd0;
          r_busy      <= 1'b0;
          r_game_over <= 1'b1;
        end
      end
    end
  end

endmodule
